// File: rtl/fetch_sequencer.sv
// Program fetch sequencer: clears the instruction counter, fetches each
// instruction from instruction memory at the current count, presents it to
// the decoder over valid/ready, and steps the counter forward or rewinds it.
module fetch_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              fs_clk,
  input  logic              fs_rst_n,
  input  logic              fs_start,
  input  logic              fs_halt,
  input  logic [ADDR_W-1:0] fs_last_addr,
  input  logic              fs_rewind,
  input  logic [ADDR_W-1:0] fs_rewind_cnt,
  input  logic [ADDR_W-1:0] fs_pc,
  output logic              fs_cnt,
  output logic              fs_dir,
  output logic              fs_clr,
  output logic              fs_mem_req,
  output logic [ADDR_W-1:0] fs_mem_addr,
  input  logic              fs_mem_ack,
  input  logic [DATA_W-1:0] fs_mem_rdata,
  output logic [DATA_W-1:0] fs_instr,
  output logic              fs_instr_valid,
  input  logic              fs_instr_ready,
  output logic              fs_busy,
  output logic              fs_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    REQ    = 3'd2,
    HOLD   = 3'd3,
    REWIND = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_STEP = ADDR_W'(1);

  state_t            state;
  logic              clr_q;
  logic              req_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              rewinding_q;
  logic              pending_q;
  logic [ADDR_W-1:0] rw_q;
  logic [DATA_W-1:0] instr_q;

  logic [ADDR_W-1:0] rw_load;
  logic              rewind_take;
  logic              step;

  // Rewind distance limited to the current count so the counter never wraps below 0.
  function automatic logic [ADDR_W-1:0] clamp_steps(input logic [ADDR_W-1:0] steps,
                                                    input logic [ADDR_W-1:0] pc);
    return (steps > pc) ? pc : steps;
  endfunction

  assign rw_load     = clamp_steps(fs_rewind_cnt, fs_pc);
  assign rewind_take = pending_q && (rw_q != '0);

  // Forward step happens in the handshake cycle itself, so it cannot be registered.
  assign step = (state == HOLD) && fs_instr_ready && !fs_halt && !rewind_take &&
                (fs_pc != fs_last_addr);

  assign fs_clr         = clr_q;
  assign fs_mem_req     = req_q;
  assign fs_mem_addr    = req_q ? fs_pc : '0;
  assign fs_instr       = instr_q;
  assign fs_instr_valid = valid_q;
  assign fs_busy        = busy_q;
  assign fs_done        = done_q;
  assign fs_dir         = rewinding_q;
  assign fs_cnt         = rewinding_q | step;

  // Sequencer FSM with registered Moore outputs and rewind bookkeeping.
  always_ff @(posedge fs_clk or negedge fs_rst_n) begin
    if (!fs_rst_n) begin
      state       <= IDLE;
      clr_q       <= 1'b0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rewinding_q <= 1'b0;
      pending_q   <= 1'b0;
      rw_q        <= '0;
      instr_q     <= '0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      if (fs_halt && (state != IDLE)) begin
        // Halt wins over ack and ready: nothing is captured, nothing steps.
        state       <= IDLE;
        req_q       <= 1'b0;
        valid_q     <= 1'b0;
        busy_q      <= 1'b0;
        rewinding_q <= 1'b0;
        pending_q   <= 1'b0;
        rw_q        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (fs_start) begin
              state  <= CLEAR;
              clr_q  <= 1'b1;
              busy_q <= 1'b1;
            end
          end
          CLEAR: begin
            state <= REQ;
            req_q <= 1'b1;
          end
          REQ: begin
            if (fs_mem_ack) begin
              instr_q <= fs_mem_rdata;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
              state   <= HOLD;
            end
          end
          HOLD: begin
            if (fs_instr_ready) begin
              valid_q <= 1'b0;
              if (rewind_take) begin
                state       <= REWIND;
                rewinding_q <= 1'b1;
              end else if (fs_pc == fs_last_addr) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state <= REQ;
                req_q <= 1'b1;
              end
            end
          end
          REWIND: begin
            // The last decrement is issued in the cycle the register holds 1.
            if (rw_q <= ONE_STEP) begin
              state       <= REQ;
              req_q       <= 1'b1;
              rewinding_q <= 1'b0;
              pending_q   <= 1'b0;
              rw_q        <= '0;
            end else begin
              rw_q <= rw_q - ONE_STEP;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            rewinding_q <= 1'b0;
          end
        endcase
        // A new rewind request overwrites any pending one.
        if (fs_rewind && (state != IDLE)) begin
          rw_q      <= rw_load;
          pending_q <= (rw_load != '0);
        end
      end
    end
  end

endmodule
